// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared state encoding and SD CRC polynomials
package sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;

endpackage

// File: rtl/sd_crc_lane.sv
// rtl/sd_crc_lane.sv - one DAT lane CRC register with its sticky mismatch flag
// Ports: clk, reset (sync, active-high), clear (zero crc and error),
//        shift (advance one bit), load_zero (1 = zero-fill shift for CRC
//        serialisation, 0 = polynomial update with data_in), check (compare
//        data_in against the outgoing MSB while serialising), data_in,
//        crc (register), error (sticky mismatch).
module sd_crc_lane #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY = 16'h1021
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             load_zero,
    input  logic             check,
    input  logic             data_in,
    output logic [WIDTH-1:0] crc,
    output logic             error
);

    logic inv;
    assign inv = crc[WIDTH-1] ^ data_in;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc   <= '0;
            error <= 1'b0;
        end else if (shift) begin
            if (load_zero) begin
                // Received CRC bit is compared against the bit leaving the register.
                if (check && (data_in != crc[WIDTH-1])) begin
                    error <= 1'b1;
                end
                crc <= {crc[WIDTH-2:0], 1'b0};
            end else begin
                crc <= {crc[WIDTH-2:0], 1'b0} ^ (inv ? POLY : '0);
            end
        end
    end

endmodule

// File: rtl/sd_crc_multi.sv
// rtl/sd_crc_multi.sv - multi-lane SD DAT CRC generator/checker
// Ports: i_clk, i_reset (sync, active-high), i_clear (start block, latch i_mode),
//        i_mode (0 generate / 1 check), i_valid (bit strobe), i_data (one bit
//        per lane), i_finish (last data bit), o_crc_data (serial CRC MSB per
//        lane), o_crc_phase, o_busy, o_done (one-cycle pulse), o_error
//        (sticky per-lane mismatch), o_crc (lane n at [n*WIDTH +: WIDTH]).
module sd_crc_multi
    import sd_pkg::*;
#(
    parameter int               LANES = 4,
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = SD_CRC16_POLY
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_mode,
    input  logic                   i_valid,
    input  logic [LANES-1:0]       i_data,
    input  logic                   i_finish,
    output logic [LANES-1:0]       o_crc_data,
    output logic                   o_crc_phase,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [LANES-1:0]       o_error,
    output logic [LANES*WIDTH-1:0] o_crc
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q;
    logic             lane_shift;
    logic             lane_zero;
    logic [LANES-1:0] crc_msb;

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_DATA;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_DATA: if (i_valid && i_finish) state_d = ST_CRC;
                ST_CRC:  if (i_valid && (cnt_q == CNT_LAST)) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_clear) begin
                cnt_q  <= '0;
                mode_q <= i_mode;
            end else if (state_q == ST_CRC && i_valid) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q != ST_CRC) begin
                cnt_q <= '0;
            end
        end
    end

    // i_clear wins over a coincident strobe, so that bit never reaches the lanes.
    assign lane_shift = i_valid && !i_clear && (state_q == ST_DATA || state_q == ST_CRC);
    assign lane_zero  = (state_q == ST_CRC);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        sd_crc_lane #(
            .WIDTH (WIDTH),
            .POLY  (POLY)
        ) u_lane (
            .clk       (i_clk),
            .reset     (i_reset),
            .clear     (i_clear),
            .shift     (lane_shift),
            .load_zero (lane_zero),
            .check     (mode_q),
            .data_in   (i_data[n]),
            .crc       (o_crc[n*WIDTH +: WIDTH]),
            .error     (o_error[n])
        );
        assign crc_msb[n] = o_crc[n*WIDTH + WIDTH - 1];
    end

    assign o_crc_data  = (state_q == ST_CRC) ? crc_msb : '0;
    assign o_crc_phase = (state_q == ST_CRC);
    assign o_busy      = (state_q == ST_DATA) || (state_q == ST_CRC);
    assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sd_crc_multi.sv
// tb/tb_sd_crc_multi.sv - directed self-checking bench for sd_crc_multi
module tb_sd_crc_multi;

    localparam int LANES = 4;
    localparam int WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   clr = 1'b0;
    logic                   mode = 1'b0;
    logic                   valid = 1'b0;
    logic [LANES-1:0]       data = '0;
    logic                   finish = 1'b0;
    logic [LANES-1:0]       crc_data;
    logic                   crc_phase;
    logic                   busy;
    logic                   done;
    logic [LANES-1:0]       error;
    logic [LANES*WIDTH-1:0] crc;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    sd_crc_multi #(.LANES(LANES), .WIDTH(WIDTH), .POLY(16'h1021)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_clear     (clr),
        .i_mode      (mode),
        .i_valid     (valid),
        .i_data      (data),
        .i_finish    (finish),
        .o_crc_data  (crc_data),
        .o_crc_phase (crc_phase),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_crc       (crc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one strobe across the following posedge.
    task automatic strobe(input logic [LANES-1:0] d, input logic fin);
        valid = 1'b1; data = d; finish = fin;
        @(negedge clk);
        valid = 1'b0; data = '0; finish = 1'b0;
    endtask

    task automatic do_clear(input logic m);
        clr = 1'b1; mode = m;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send_msg(input logic [LANES-1:0] en, input bit gaps);
        for (int i = 0; i < 9; i++) begin
            for (int b = 7; b >= 0; b--) begin
                if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                strobe(msg[i][b] ? en : '0, (i == 8) && (b == 0));
            end
        end
    endtask

    initial begin
        logic [15:0] ex;
        logic [15:0] bad;
        logic [3:0]  d;
        ex  = 16'h31C3;
        bad = 16'h31C2;

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_crc", crc, 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_phase", 64'(crc_phase), 64'd0);
        chk("rst_crc_data", 64'(crc_data), 64'd0);

        strobe(4'hF, 1'b0);
        chk("idle_valid_ignored", crc, 64'd0);
        chk("idle_not_busy", 64'(busy), 64'd0);

        do_clear(1'b0);
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_phase", 64'(crc_phase), 64'd0);
        send_msg(4'hF, 1'b0);
        chk("gen_crc_123456789", crc, {4{16'h31C3}});
        chk("gen_phase", 64'(crc_phase), 64'd1);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("gen_crc_bit%0d", k), 64'(crc_data), 64'({4{ex[15-k]}}));
            strobe(4'h0, 1'b0);
        end
        chk("gen_done_pulse", 64'(done), 64'd1);
        chk("gen_crc_zero_after", crc, 64'd0);
        chk("gen_crc_data_outside", 64'(crc_data), 64'd0);
        @(negedge clk);
        chk("gen_done_one_cycle", 64'(done), 64'd0);
        chk("gen_idle_busy", 64'(busy), 64'd0);

        do_clear(1'b0);
        for (int i = 0; i < 4095; i++) strobe(4'hF, 1'b0);
        strobe(4'hF, 1'b1);
        chk("ff_block_crc", crc, {4{16'h7FA1}});

        do_clear(1'b0);
        send_msg(4'b1011, 1'b0);
        chk("lane2_zero", crc, {16'h31C3, 16'h0000, 16'h31C3, 16'h31C3});

        for (int k = 0; k < 5; k++) strobe(4'h0, 1'b0);
        chk("abort_in_crc", 64'(crc_phase), 64'd1);
        do_clear(1'b0);
        chk("abort_busy", 64'(busy), 64'd1);
        chk("abort_phase", 64'(crc_phase), 64'd0);
        chk("abort_crc", crc, 64'd0);
        chk("abort_no_done", 64'(done), 64'd0);
        clr = 1'b1; valid = 1'b1; data = 4'hF;
        @(negedge clk);
        clr = 1'b0; valid = 1'b0; data = '0;
        chk("clear_vs_valid", crc, 64'd0);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("finish_without_valid", 64'(crc_phase), 64'd0);

        do_clear(1'b1);
        send_msg(4'hF, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("chk_no_error_early", 64'(error), 64'd0);
            d = {ex[15-k], bad[15-k], ex[15-k], ex[15-k]};
            strobe(d, 1'b0);
        end
        chk("chk_done", 64'(done), 64'd1);
        chk("chk_error_lane2", 64'(error), 64'b0100);
        do_clear(1'b1);
        chk("chk_error_cleared", 64'(error), 64'd0);

        do_clear(1'b0);
        send_msg(4'hF, 1'b1);
        chk("gaps_crc", crc, {4{16'h31C3}});

        do_clear(1'b0);
        strobe(4'b0001, 1'b1);
        chk("zero_len_crc", crc, 64'h0000_0000_0000_1021);
        chk("zero_len_phase", 64'(crc_phase), 64'd1);
        chk("zero_len_msb", 64'(crc_data), 64'd0);

        do_clear(1'b1);
        strobe(4'hF, 1'b0);
        strobe(4'hA, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_crc", crc, 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_phase", 64'(crc_phase), 64'd0);
        chk("midrst_error", 64'(error), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
